// File: rtl/toll_gate_fsm.sv
// toll_gate_fsm: registered toll-lane controller.
// Latches axle count and time of day on arrival, computes the toll from
// per-axle band rates, converts it to BCD with a 10-step double-dabble,
// then runs the STOP/GO payment handshake.
// Optional build macro TOLL_VIOLATION_EN adds a WAIT_PAY timeout that
// releases unpaid vehicles as violations and counts them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | lane empty, STOP shown, waiting for a vehicle
// CALC     | toll computed from latched axles/time
// CONV     | 10 double-dabble steps on TOLL[9:0]
// WAIT_PAY | digits shown, waiting for TOLL_PAID (or timeout)
// PASS     | paid, GO shown until the vehicle leaves
// VIOL     | unpaid release, GO + VIOLATION until the vehicle leaves
module toll_gate_fsm #(
  parameter int AXLE_MAX    = 4,
  parameter int RATE_OFF    = 15,
  parameter int RATE_AM     = 45,
  parameter int RATE_MID    = 25,
  parameter int RATE_PM     = 50,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VEHICLE,
  input  logic [2:0]       AXLES,
  input  logic [12:0]      CLOCK,
  input  logic             TOLL_PAID,
  output logic [15:0]      TOLL,
  output logic [3:0]       BCD_DOLLARS,
  output logic [3:0]       BCD_CENTS_MSB,
  output logic [3:0]       BCD_CENTS_LSB,
  output logic             GO,
  output logic             STOP,
  output logic             BUSY,
  output logic             VIOLATION,
  output logic [CNT_W-1:0] VEH_COUNT,
  output logic [CNT_W-1:0] VIOL_COUNT
);

  localparam int RATE_MAX_AO = (RATE_AM > RATE_OFF) ? RATE_AM : RATE_OFF;
  localparam int RATE_MAX_MP = (RATE_MID > RATE_PM) ? RATE_MID : RATE_PM;
  localparam int RATE_MAX    = (RATE_MAX_AO > RATE_MAX_MP) ? RATE_MAX_AO : RATE_MAX_MP;

  // The toll must fit three BCD digits; the 10-step conversion relies on it.
  if (AXLE_MAX < 2 || AXLE_MAX > 7 || AXLE_MAX * RATE_MAX > 999 ||
      TIMEOUT_CYC < 1 || CNT_W < 1) begin : g_bad_param
    $error("toll_gate_fsm: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, CALC, CONV, WAIT_PAY, PASS, VIOL} state_t;

  state_t      state;
  logic [2:0]  axles_q;
  logic [12:0] clock_q;
  logic [2:0]  eff_axles;
  logic [9:0]  rate;
  logic [15:0] toll_calc;
  logic [11:0] dd_bcd;
  logic [9:0]  dd_bin;
  logic [11:0] bcd_adj;
  logic [21:0] dd_next;
  logic [3:0]  step_q;

  // Toll from the latched arrival data: clamped axle count times band rate.
  always_comb begin
    eff_axles = axles_q;
    if (axles_q < 3'd2)
      eff_axles = 3'd2;
    else if (axles_q > 3'(AXLE_MAX))
      eff_axles = 3'(AXLE_MAX);
    rate = 10'(RATE_OFF);
    if (clock_q >= 13'd420 && clock_q < 13'd600)
      rate = 10'(RATE_AM);
    else if (clock_q >= 13'd600 && clock_q < 13'd900)
      rate = 10'(RATE_MID);
    else if (clock_q >= 13'd900 && clock_q < 13'd1200)
      rate = 10'(RATE_PM);
    toll_calc = 16'(eff_axles) * 16'(rate);
  end

  // One double-dabble step: add 3 to any digit >= 5, then shift left.
  always_comb begin
    bcd_adj = dd_bcd;
    for (int i = 0; i < 3; i++) begin
      if (dd_bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
    end
    dd_next = {bcd_adj, dd_bin} << 1;
  end

`ifdef TOLL_VIOLATION_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;
`endif

  // Main controller: state, datapath registers and all registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      axles_q       <= '0;
      clock_q       <= '0;
      TOLL          <= '0;
      dd_bcd        <= '0;
      dd_bin        <= '0;
      step_q        <= '0;
      BCD_DOLLARS   <= '0;
      BCD_CENTS_MSB <= '0;
      BCD_CENTS_LSB <= '0;
      GO            <= 1'b0;
      STOP          <= 1'b1;
      BUSY          <= 1'b0;
      VEH_COUNT     <= '0;
`ifdef TOLL_VIOLATION_EN
      tmo_q         <= '0;
      VIOLATION     <= 1'b0;
      VIOL_COUNT    <= '0;
`endif
    end else begin
      // Returning to IDLE always blanks the toll display and shows STOP;
      // branches below override these defaults when staying busy.
      if (state != IDLE && !VEHICLE) begin
        state         <= IDLE;
        TOLL          <= '0;
        BCD_DOLLARS   <= '0;
        BCD_CENTS_MSB <= '0;
        BCD_CENTS_LSB <= '0;
        GO            <= 1'b0;
        STOP          <= 1'b1;
        BUSY          <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (VEHICLE) begin
            axles_q <= AXLES;
            clock_q <= CLOCK;
            state   <= CALC;
            BUSY    <= 1'b1;
          end
        end
        CALC: begin
          if (VEHICLE) begin
            TOLL   <= toll_calc;
            dd_bcd <= '0;
            dd_bin <= toll_calc[9:0];
            step_q <= 4'd9;
            state  <= CONV;
          end
        end
        CONV: begin
          if (VEHICLE) begin
            {dd_bcd, dd_bin} <= dd_next;
            if (step_q == 4'd0) begin
              BCD_DOLLARS   <= dd_next[21:18];
              BCD_CENTS_MSB <= dd_next[17:14];
              BCD_CENTS_LSB <= dd_next[13:10];
              state         <= WAIT_PAY;
`ifdef TOLL_VIOLATION_EN
              tmo_q         <= TW'(TIMEOUT_CYC - 1);
`endif
            end else begin
              step_q <= step_q - 4'd1;
            end
          end
        end
        WAIT_PAY: begin
          if (VEHICLE) begin
            if (TOLL_PAID) begin
              state <= PASS;
              GO    <= 1'b1;
              STOP  <= 1'b0;
            end
`ifdef TOLL_VIOLATION_EN
            else if (tmo_q == '0) begin
              state     <= VIOL;
              GO        <= 1'b1;
              STOP      <= 1'b0;
              VIOLATION <= 1'b1;
            end else begin
              tmo_q <= tmo_q - TW'(1);
            end
`endif
          end
        end
        PASS: begin
          if (!VEHICLE)
            VEH_COUNT <= VEH_COUNT + CNT_W'(1);
        end
`ifdef TOLL_VIOLATION_EN
        VIOL: begin
          if (!VEHICLE) begin
            VIOLATION  <= 1'b0;
            VIOL_COUNT <= VIOL_COUNT + CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef TOLL_VIOLATION_EN
  assign VIOLATION  = 1'b0;
  assign VIOL_COUNT = '0;
`endif

endmodule

// File: tb/tb_toll_gate_fsm.sv
// Directed bench for toll_gate_fsm: a table of toll vectors run through the
// full payment handshake, plus hand-written abort, timeout and reset cases.
module tb_toll_gate_fsm;

  logic        clk_sys;
  logic        rst_n;
  logic        vehicle;
  logic [2:0]  axles;
  logic [12:0] clock_min;
  logic        toll_paid;
  logic [15:0] toll;
  logic [3:0]  bcd_d, bcd_cm, bcd_cl;
  logic        go, stop, busy, violation;
  logic [3:0]  veh_count, viol_count;

  int checks = 0;
  int errors = 0;
  int exp_veh = 0;

  toll_gate_fsm #(.TIMEOUT_CYC(20), .CNT_W(4)) dut (
    .CLK(clk_sys), .RESET(rst_n), .VEHICLE(vehicle), .AXLES(axles),
    .CLOCK(clock_min), .TOLL_PAID(toll_paid), .TOLL(toll),
    .BCD_DOLLARS(bcd_d), .BCD_CENTS_MSB(bcd_cm), .BCD_CENTS_LSB(bcd_cl),
    .GO(go), .STOP(stop), .BUSY(busy), .VIOLATION(violation),
    .VEH_COUNT(veh_count), .VIOL_COUNT(viol_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [2:0]  ax;
    logic [12:0] minute;
    int          toll;
    int          d, cm, cl;
  } vec_t;

  vec_t vecs[15];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Full paid transaction with latency checks at k, k+1, k+10, k+11.
  task automatic run_txn(input vec_t v);
    vehicle = 1'b1; axles = v.ax; clock_min = v.minute;
    tick();
    chk("busy_k", int'(busy), 1);
    axles = 3'd5; clock_min = 13'd1000;
    tick();
    chk("toll_k1", int'(toll), v.toll);
    repeat (9) tick();
    chk("bcd_not_yet", int'({bcd_d, bcd_cm, bcd_cl}), 0);
    tick();
    chk("bcd_dollars", int'(bcd_d), v.d);
    chk("bcd_cents_msb", int'(bcd_cm), v.cm);
    chk("bcd_cents_lsb", int'(bcd_cl), v.cl);
    chk("go_wait", int'(go), 0);
    chk("stop_wait", int'(stop), 1);
    toll_paid = 1'b1;
    tick();
    chk("go_paid", int'(go), 1);
    chk("stop_paid", int'(stop), 0);
    toll_paid = 1'b0; vehicle = 1'b0;
    tick();
    exp_veh++;
    chk("go_leave", int'(go), 0);
    chk("stop_leave", int'(stop), 1);
    chk("busy_leave", int'(busy), 0);
    chk("toll_cleared", int'(toll), 0);
    chk("veh_count", int'(veh_count), exp_veh % 16);
  endtask

  initial begin
    vecs[0]  = '{3'd2, 13'd480,  90,  0, 9, 0};
    vecs[1]  = '{3'd4, 13'd960,  200, 2, 0, 0};
    vecs[2]  = '{3'd3, 13'd660,  75,  0, 7, 5};
    vecs[3]  = '{3'd7, 13'd2,    60,  0, 6, 0};
    vecs[4]  = '{3'd1, 13'd1300, 30,  0, 3, 0};
    vecs[5]  = '{3'd4, 13'd419,  60,  0, 6, 0};
    vecs[6]  = '{3'd4, 13'd420,  180, 1, 8, 0};
    vecs[7]  = '{3'd3, 13'd599,  135, 1, 3, 5};
    vecs[8]  = '{3'd2, 13'd600,  50,  0, 5, 0};
    vecs[9]  = '{3'd4, 13'd899,  100, 1, 0, 0};
    vecs[10] = '{3'd4, 13'd900,  200, 2, 0, 0};
    vecs[11] = '{3'd4, 13'd1199, 200, 2, 0, 0};
    vecs[12] = '{3'd4, 13'd1200, 60,  0, 6, 0};
    vecs[13] = '{3'd2, 13'd1440, 30,  0, 3, 0};
    vecs[14] = '{3'd0, 13'd500,  90,  0, 9, 0};

    rst_n = 1'b0; vehicle = 1'b0; axles = '0; clock_min = '0; toll_paid = 1'b0;
    #22;
    chk("rst_toll", int'(toll), 0);
    chk("rst_bcd", int'({bcd_d, bcd_cm, bcd_cl}), 0);
    chk("rst_go", int'(go), 0);
    chk("rst_stop", int'(stop), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_violation", int'(violation), 0);
    chk("rst_veh_count", int'(veh_count), 0);
    chk("rst_viol_count", int'(viol_count), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_txn(vecs[i]);

    // Vehicle backs out during CONV; a TOLL_PAID pulse there is ignored.
    vehicle = 1'b1; axles = 3'd3; clock_min = 13'd660;
    tick(); tick(); tick(); tick();
    toll_paid = 1'b1;
    tick();
    chk("conv_paid_go", int'(go), 0);
    chk("conv_paid_busy", int'(busy), 1);
    toll_paid = 1'b0; vehicle = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_toll", int'(toll), 0);
    chk("abort_stop", int'(stop), 1);
    chk("abort_veh_count", int'(veh_count), exp_veh % 16);

    // TOLL_PAID held through CONV; then pay and back-out in the same cycle.
    vehicle = 1'b1; axles = 3'd4; clock_min = 13'd960;
    tick(); tick();
    toll_paid = 1'b1;
    repeat (9) tick();
    chk("paid_conv_go", int'(go), 0);
    tick();
    chk("paid_conv_wait_go", int'(go), 0);
    chk("paid_conv_bcd", int'(bcd_d), 2);
    vehicle = 1'b0;
    tick();
    chk("both_busy", int'(busy), 0);
    chk("both_go", int'(go), 0);
    chk("both_bcd", int'(bcd_d), 0);
    chk("both_veh_count", int'(veh_count), exp_veh % 16);
    toll_paid = 1'b0;
    tick();

`ifdef TOLL_VIOLATION_EN
    // No payment: violation exactly 20 edges after WAIT_PAY entry.
    vehicle = 1'b1; axles = 3'd2; clock_min = 13'd480;
    repeat (12) tick();
    repeat (19) tick();
    chk("tmo_early_viol", int'(violation), 0);
    chk("tmo_early_go", int'(go), 0);
    tick();
    chk("tmo_viol", int'(violation), 1);
    chk("tmo_go", int'(go), 1);
    chk("tmo_stop", int'(stop), 0);
    vehicle = 1'b0;
    tick();
    chk("tmo_viol_clear", int'(violation), 0);
    chk("tmo_viol_count", int'(viol_count), 1);
    chk("tmo_veh_count", int'(veh_count), exp_veh % 16);
    // Payment on the timeout edge wins.
    vehicle = 1'b1;
    repeat (12) tick();
    repeat (19) tick();
    toll_paid = 1'b1;
    tick();
    chk("tmo_pay_viol", int'(violation), 0);
    chk("tmo_pay_go", int'(go), 1);
    toll_paid = 1'b0; vehicle = 1'b0;
    tick();
    exp_veh++;
    chk("tmo_pay_count", int'(veh_count), exp_veh % 16);
    chk("tmo_pay_viol_count", int'(viol_count), 1);
`else
    // Without the timeout path the lane waits indefinitely.
    vehicle = 1'b1; axles = 3'd2; clock_min = 13'd480;
    repeat (12) tick();
    repeat (40) tick();
    chk("nt_violation", int'(violation), 0);
    chk("nt_go", int'(go), 0);
    chk("nt_stop", int'(stop), 1);
    chk("nt_viol_count", int'(viol_count), 0);
    vehicle = 1'b0;
    tick();
`endif

    // Asynchronous reset while in PASS.
    vehicle = 1'b1; axles = 3'd2; clock_min = 13'd480;
    repeat (12) tick();
    toll_paid = 1'b1;
    tick();
    chk("pre_rst_go", int'(go), 1);
    toll_paid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_go", int'(go), 0);
    chk("arst_stop", int'(stop), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_veh_count", int'(veh_count), 0);
    chk("arst_viol_count", int'(viol_count), 0);
    vehicle = 1'b0;
    #1 rst_n = 1'b1;
    exp_veh = 0;
    tick();

    // 16 paid vehicles wrap the 4-bit counter back to 0.
    for (int i = 0; i < 16; i++) run_txn(vecs[i % 15]);
    chk("wrap_count", int'(veh_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
